// File: rtl/pixel_scan_gen_if.sv
// Pixel-coordinate link between the scan generator and the mapper.
// master: drives coords/valid/view snapshot; slave: drives the stall signals.
interface pixel_scan_gen_if #(
  parameter int PIXEL_DATA_WIDTH  = 10,
  parameter int ENGINE_DATA_WIDTH = 25
);
  logic [PIXEL_DATA_WIDTH-1:0]         pixel_x_out;
  logic [PIXEL_DATA_WIDTH-1:0]         pixel_y_out;
  logic                                pixel_valid;
  logic [2:0]                          zoom_out;
  logic signed [ENGINE_DATA_WIDTH-1:0] x_offset_out;
  logic signed [ENGINE_DATA_WIDTH-1:0] y_offset_out;
  logic                                full_queue;
  logic                                distributor_ready;

  modport master (
    output pixel_x_out,
    output pixel_y_out,
    output pixel_valid,
    output zoom_out,
    output x_offset_out,
    output y_offset_out,
    input  full_queue,
    input  distributor_ready
  );

  modport slave (
    input  pixel_x_out,
    input  pixel_y_out,
    input  pixel_valid,
    input  zoom_out,
    input  x_offset_out,
    input  y_offset_out,
    output full_queue,
    output distributor_ready
  );
endinterface

// File: rtl/pixel_scan_gen.sv
// Raster scan generator: walks (x,y) over the screen one pixel per mapper
// capture (en & ~full_queue & ~distributor_ready) with a frame-latched view.
// Ports: clk, reset (async, active-high), en, start, abort, zoom_in,
//   x_offset_in, y_offset_in, pix (pixel_scan_gen_if.master: coords, valid,
//   view snapshot out; full_queue/distributor_ready in), busy, frame_done,
//   frame_count.
// Option: define PIXEL_SCAN_VIEW_RESTART_EN to restart the frame whenever
//   the requested view differs from the latched one during a scan.
module pixel_scan_gen #(
  parameter int PIXEL_DATA_WIDTH  = 10,
  parameter int ENGINE_DATA_WIDTH = 25,
  parameter int SCREEN_WIDTH      = 640,
  parameter int SCREEN_HEIGHT     = 480
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                en,
  input  logic                                start,
  input  logic                                abort,
  input  logic [2:0]                          zoom_in,
  input  logic signed [ENGINE_DATA_WIDTH-1:0] x_offset_in,
  input  logic signed [ENGINE_DATA_WIDTH-1:0] y_offset_in,
  pixel_scan_gen_if.master                    pix,
  output logic                                busy,
  output logic                                frame_done,
  output logic [15:0]                         frame_count
);
  localparam int PW = PIXEL_DATA_WIDTH;
  localparam int EW = ENGINE_DATA_WIDTH;
  localparam logic [PW-1:0] X_LAST = PW'(SCREEN_WIDTH - 1);
  localparam logic [PW-1:0] Y_LAST = PW'(SCREEN_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         x_q, x_d;
  logic [PW-1:0]         y_q, y_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [2:0]            zoom_q, zoom_d;
  logic signed [EW-1:0]  xoff_q, xoff_d;
  logic signed [EW-1:0]  yoff_q, yoff_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic                  advance;
  logic                  view_chg;

  assign advance = en & ~pix.full_queue & ~pix.distributor_ready;

`ifdef PIXEL_SCAN_VIEW_RESTART_EN
  assign view_chg = (zoom_in != zoom_q)
                  | (x_offset_in != xoff_q)
                  | (y_offset_in != yoff_q);
`else
  assign view_chg = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    valid_d       = valid_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    zoom_d        = zoom_q;
    xoff_d        = xoff_q;
    yoff_d        = yoff_q;
    frame_count_d = frame_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          zoom_d  = zoom_in;
          xoff_d  = x_offset_in;
          yoff_d  = y_offset_in;
          x_d     = '0;
          y_d     = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        unique case (1'b1)
          abort: begin
            x_d     = '0;
            y_d     = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
          (!abort && view_chg): begin
            // New view requested mid-frame: start over from (0,0).
            zoom_d = zoom_in;
            xoff_d = x_offset_in;
            yoff_d = y_offset_in;
            x_d    = '0;
            y_d    = '0;
          end
          (!abort && !view_chg && advance): begin
            if (x_q != X_LAST) begin
              x_d = x_q + PW'(1);
            end else if (y_q != Y_LAST) begin
              x_d = '0;
              y_d = y_q + PW'(1);
            end else begin
              // Last pixel captured; x/y keep their final value.
              valid_d       = 1'b0;
              done_d        = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
              state_d       = S_DONE;
            end
          end
          default: ;
        endcase
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (abort) begin
          x_d = '0;
          y_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      zoom_q        <= '0;
      xoff_q        <= '0;
      yoff_q        <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      zoom_q        <= zoom_d;
      xoff_q        <= xoff_d;
      yoff_q        <= yoff_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign pix.pixel_x_out  = x_q;
  assign pix.pixel_y_out  = y_q;
  assign pix.pixel_valid  = valid_q;
  assign pix.zoom_out     = zoom_q;
  assign pix.x_offset_out = xoff_q;
  assign pix.y_offset_out = yoff_q;
  assign busy             = busy_q;
  assign frame_done       = done_q;
  assign frame_count      = frame_count_q;
endmodule

// File: tb/tb_pixel_scan_gen.sv
// Scoreboard bench for pixel_scan_gen on a 4x3 screen.
// Stimulus pushes expected captures/frame counts; a monitor pops and compares.
module tb_pixel_scan_gen;
  localparam int PW = 10;
  localparam int EW = 25;
  localparam int SW = 4;
  localparam int SH = 3;

  typedef struct packed {
    logic [PW-1:0] x;
    logic [PW-1:0] y;
    logic [2:0]    z;
    logic [EW-1:0] xo;
    logic [EW-1:0] yo;
  } pix_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 en;
  logic                 start;
  logic                 abort;
  logic [2:0]           zoom_in;
  logic signed [EW-1:0] x_offset_in;
  logic signed [EW-1:0] y_offset_in;
  logic                 busy;
  logic                 frame_done;
  logic [15:0]          frame_count;

  pixel_scan_gen_if #(
    .PIXEL_DATA_WIDTH (PW),
    .ENGINE_DATA_WIDTH(EW)
  ) pif ();

  pixel_scan_gen #(
    .PIXEL_DATA_WIDTH (PW),
    .ENGINE_DATA_WIDTH(EW),
    .SCREEN_WIDTH     (SW),
    .SCREEN_HEIGHT    (SH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .start      (start),
    .abort      (abort),
    .zoom_in    (zoom_in),
    .x_offset_in(x_offset_in),
    .y_offset_in(y_offset_in),
    .pix        (pif),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  pix_t        exp_q[$];
  logic [15:0] fc_q[$];
  int          checks = 0;
  int          fails  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_pix(input int n, input logic [2:0] z,
                          input logic [EW-1:0] xo, input logic [EW-1:0] yo);
    pix_t p;
    for (int i = 0; i < n; i++) begin
      p.x  = PW'(i % SW);
      p.y  = PW'(i / SW);
      p.z  = z;
      p.xo = xo;
      p.yo = yo;
      exp_q.push_back(p);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40 && busy; i++) tick();
    check(name, {63'd0, busy}, 64'd0);
  endtask

  task automatic check_xy(input string name, input int x, input int y);
    check(name, {44'd0, pif.pixel_x_out, pif.pixel_y_out},
          {44'd0, PW'(x), PW'(y)});
  endtask

  // Monitor: every mapper capture and every frame_done pulse is scored.
  initial begin
    pix_t act;
    pix_t exp;
    logic [15:0] efc;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pif.pixel_valid && en && !pif.full_queue &&
            !pif.distributor_ready) begin
          act = {pif.pixel_x_out, pif.pixel_y_out, pif.zoom_out,
                 pif.x_offset_out, pif.y_offset_out};
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL pix_extra: got (%0d,%0d) expected none",
                     act.x, act.y);
          end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
              fails++;
              $display("FAIL pix: got (%0d,%0d) z=%0d xo=%0h yo=%0h expected (%0d,%0d) z=%0d xo=%0h yo=%0h",
                       act.x, act.y, act.z, act.xo, act.yo,
                       exp.x, exp.y, exp.z, exp.xo, exp.yo);
            end
          end
        end
        if (frame_done) begin
          checks++;
          if (fc_q.size() == 0) begin
            fails++;
            $display("FAIL done_extra: got frame_done count=%0h expected none",
                     frame_count);
          end else begin
            efc = fc_q.pop_front();
            if (frame_count !== efc) begin
              fails++;
              $display("FAIL done_count: got %0h expected %0h",
                       frame_count, efc);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    en = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    zoom_in = '0;
    x_offset_in = '0;
    y_offset_in = '0;
    pif.full_queue = 1'b0;
    pif.distributor_ready = 1'b0;
    repeat (3) tick();

    check("rst_valid", {63'd0, pif.pixel_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, frame_done}, 64'd0);
    check("rst_count", {48'd0, frame_count}, 64'd0);
    check_xy("rst_xy", 0, 0);
    check("rst_zoom", {61'd0, pif.zoom_out}, 64'd0);
    reset = 1'b0;
    tick();

    // Plain frame, no stalls.
    zoom_in = 3'd2;
    x_offset_in = 25'h0012345;
    y_offset_in = 25'h1FFFFFB;
    push_pix(12, 3'd2, 25'h0012345, 25'h1FFFFFB);
    fc_q.push_back(16'd1);
    pulse_start();
    check("f1_busy", {63'd0, busy}, 64'd1);
    check_xy("f1_first", 0, 0);
    repeat (12) tick();
    check("f1_done", {63'd0, frame_done}, 64'd1);
    check("f1_done_valid", {63'd0, pif.pixel_valid}, 64'd0);
    check_xy("f1_last_xy", 3, 2);
    tick();
    check("f1_idle_busy", {63'd0, busy}, 64'd0);
    check("f1_idle_done", {63'd0, frame_done}, 64'd0);
    check("f1_count", {48'd0, frame_count}, 64'd1);

    // Stalls from each source.
    zoom_in = 3'd1;
    x_offset_in = '0;
    y_offset_in = '0;
    push_pix(12, 3'd1, '0, '0);
    fc_q.push_back(16'd2);
    pulse_start();
    repeat (6) tick();
    check_xy("st_pre", 2, 1);
    pif.full_queue = 1'b1;
    repeat (3) begin
      tick();
      check_xy("st_fq_hold", 2, 1);
    end
    pif.full_queue = 1'b0;
    tick();
    check_xy("st_fq_resume", 3, 1);
    pif.distributor_ready = 1'b1;
    repeat (3) begin
      tick();
      check_xy("st_dr_hold", 3, 1);
    end
    pif.distributor_ready = 1'b0;
    tick();
    check_xy("st_dr_resume", 0, 2);
    en = 1'b0;
    repeat (3) begin
      tick();
      check_xy("st_en_hold", 0, 2);
    end
    en = 1'b1;
    tick();
    check_xy("st_en_resume", 1, 2);
    wait_idle("st_idle");
    check("st_count", {48'd0, frame_count}, 64'd2);

    // View snapshot; inputs change mid-frame.
    zoom_in = 3'd3;
    x_offset_in = 25'h0100000;
    y_offset_in = '0;
`ifdef PIXEL_SCAN_VIEW_RESTART_EN
    push_pix(5, 3'd3, 25'h0100000, '0);
    push_pix(12, 3'd5, 25'h0100000, '0);
`else
    push_pix(12, 3'd3, 25'h0100000, '0);
`endif
    fc_q.push_back(16'd3);
    pulse_start();
    repeat (4) tick();
    zoom_in = 3'd5;
    tick();
`ifdef PIXEL_SCAN_VIEW_RESTART_EN
    check_xy("vw_restart", 0, 0);
    check("vw_zoom", {61'd0, pif.zoom_out}, 64'd5);
`else
    check_xy("vw_continue", 1, 1);
    check("vw_zoom", {61'd0, pif.zoom_out}, 64'd3);
`endif
    check("vw_xoff", {39'd0, pif.x_offset_out}, 64'h0100000);
    wait_idle("vw_idle");
    check("vw_count", {48'd0, frame_count}, 64'd3);
    zoom_in = 3'd0;
    x_offset_in = '0;

    // Abort at (1,2); (1,2) is still captured on the abort edge.
    push_pix(10, 3'd0, '0, '0);
    pulse_start();
    repeat (9) tick();
    check_xy("ab_at", 1, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_valid", {63'd0, pif.pixel_valid}, 64'd0);
    check("ab_busy", {63'd0, busy}, 64'd0);
    check_xy("ab_xy", 0, 0);
    check("ab_count", {48'd0, frame_count}, 64'd3);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", {63'd0, busy}, 64'd0);
    tick();
    check("sa_valid", {63'd0, pif.pixel_valid}, 64'd0);

    // Counter wrap.
    force dut.frame_count_q = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    tick();
    push_pix(12, 3'd0, '0, '0);
    fc_q.push_back(16'h0000);
    pulse_start();
    wait_idle("wr_idle");
    check("wr_count", {48'd0, frame_count}, 64'd0);

    // Async reset mid-frame.
    zoom_in = 3'd6;
    push_pix(5, 3'd6, '0, '0);
    pulse_start();
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("ar_valid", {63'd0, pif.pixel_valid}, 64'd0);
    check("ar_busy", {63'd0, busy}, 64'd0);
    check_xy("ar_xy", 0, 0);
    check("ar_zoom", {61'd0, pif.zoom_out}, 64'd0);
    check("ar_done", {63'd0, frame_done}, 64'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("ar_done_after", {63'd0, frame_done}, 64'd0);

    check("sb_pix_left", 64'(exp_q.size()), 64'd0);
    check("sb_fc_left", 64'(fc_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
